// File: rtl/vehicle_sensor_pkg.sv
// Shared types and limits for the vehicle sensor front end: ranger FSM states,
// output widths, saturation values and the speed clamp helper.
package vehicle_sensor_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        DONE
    } ranger_state_t;

    localparam int SPEED_W = 8;
    localparam int DIST_W  = 7;

    localparam logic [SPEED_W-1:0] SPEED_MAX = 8'd255;
    localparam logic [DIST_W-1:0]  DIST_MAX  = 7'd127;

    function automatic logic [SPEED_W-1:0] sat_speed(input logic [31:0] value);
        return (value > 32'(SPEED_MAX)) ? SPEED_MAX : value[SPEED_W-1:0];
    endfunction

endpackage

// File: rtl/echo_ranger.sv
// Periodic ultrasonic ranging: free-running ping counter, trigger pulse, echo
// width measurement in metres with timeout, and the distance output strobe.
module echo_ranger
    import vehicle_sensor_pkg::*;
#(
    parameter int TRIG_CYCLES      = 10,
    parameter int CYCLES_PER_METER = 58,
    parameter int ECHO_TIMEOUT     = 8000,
    parameter int PING_PERIOD      = 10000
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              echo,
    output logic              trig,
    output logic [DIST_W-1:0] leading_distance,
    output logic              dist_valid
);

    localparam int CNT_MAX = (ECHO_TIMEOUT > TRIG_CYCLES) ? ECHO_TIMEOUT : TRIG_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int PING_W  = (PING_PERIOD > 1) ? $clog2(PING_PERIOD) : 1;
    localparam int SUB_W   = (CYCLES_PER_METER > 1) ? $clog2(CYCLES_PER_METER) : 1;

    ranger_state_t     state_q, state_d;
    logic [PING_W-1:0] ping_cnt_q, ping_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [DIST_W-1:0] meters_q, meters_d;
    logic [DIST_W-1:0] dist_q, dist_d;
    logic              echo_prev_q, echo_prev_d;
    logic              echo_rise;

    // One echo-high cycle: advance the sub-metre counter, carrying into saturating metres.
    function automatic logic [SUB_W+DIST_W-1:0] count_step(input logic [SUB_W-1:0] s,
                                                           input logic [DIST_W-1:0] m);
        if (s == SUB_W'(CYCLES_PER_METER - 1)) begin
            return {SUB_W'(0), (m == DIST_MAX) ? m : m + 1'b1};
        end
        return {s + 1'b1, m};
    endfunction

    assign echo_rise        = echo & ~echo_prev_q;
    assign trig             = (state_q == TRIG);
    assign dist_valid       = (state_q == DONE);
    assign leading_distance = dist_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sub_d       = sub_q;
        meters_d    = meters_q;
        dist_d      = dist_q;
        echo_prev_d = echo;
        ping_cnt_d  = (ping_cnt_q == PING_W'(PING_PERIOD - 1)) ? '0 : ping_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (ping_cnt_q == '0) begin
                    state_d = TRIG;
                    cnt_d   = '0;
                end
            end
            TRIG: begin
                if (cnt_q == CNT_W'(TRIG_CYCLES - 1)) begin
                    state_d = WAIT_ECHO;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_ECHO: begin
                // The rising-edge cycle is itself the first echo-high cycle measured.
                if (echo_rise) begin
                    state_d           = MEASURE;
                    cnt_d             = '0;
                    {sub_d, meters_d} = count_step('0, '0);
                end else if (cnt_q == CNT_W'(ECHO_TIMEOUT - 1)) begin
                    state_d = DONE;
                    dist_d  = DIST_MAX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MEASURE: begin
                if (!echo) begin
                    state_d = DONE;
                    dist_d  = meters_q;
                end else if (cnt_q == CNT_W'(ECHO_TIMEOUT - 1)) begin
                    state_d = DONE;
                    dist_d  = DIST_MAX;
                end else begin
                    cnt_d             = cnt_q + 1'b1;
                    {sub_d, meters_d} = count_step(sub_q, meters_q);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q     <= IDLE;
            ping_cnt_q  <= '0;
            cnt_q       <= '0;
            sub_q       <= '0;
            meters_q    <= '0;
            dist_q      <= '0;
            echo_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ping_cnt_q  <= ping_cnt_d;
            cnt_q       <= cnt_d;
            sub_q       <= sub_d;
            meters_q    <= meters_d;
            dist_q      <= dist_d;
            echo_prev_q <= echo_prev_d;
        end
    end

endmodule

// File: rtl/vehicle_sensor_frontend.sv
// Sensor front end: wheel-tick speed gate plus echo ranger. Define SPEED_AVG_EN
// to report the average of the last four window speeds instead of the raw one.
module vehicle_sensor_frontend
    import vehicle_sensor_pkg::*;
#(
    parameter int WINDOW_CYCLES    = 1000,
    parameter int KMH_PER_TICK     = 1,
    parameter int TRIG_CYCLES      = 10,
    parameter int CYCLES_PER_METER = 58,
    parameter int ECHO_TIMEOUT     = 8000,
    parameter int PING_PERIOD      = 10000
) (
    input  logic               CLK,
    input  logic               rst,
    input  logic               wheel_tick,
    input  logic               echo,
    output logic               trig,
    output logic [SPEED_W-1:0] car_speed,
    output logic               speed_valid,
    output logic [DIST_W-1:0]  leading_distance,
    output logic               dist_valid
);

    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

    logic               tick_prev_q, tick_prev_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [SPEED_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic               speed_valid_q, speed_valid_d;
    logic               tick_rise;
    logic               window_end;
    logic [SPEED_W-1:0] raw_speed;
    logic [SPEED_W-1:0] speed_new;

    assign tick_rise   = wheel_tick & ~tick_prev_q;
    assign window_end  = (win_cnt_q == WIN_W'(WINDOW_CYCLES - 1));
    assign raw_speed   = sat_speed(32'(tick_cnt_q) * 32'(KMH_PER_TICK));
    assign car_speed   = speed_q;
    assign speed_valid = speed_valid_q;

`ifdef SPEED_AVG_EN
    logic [SPEED_W-1:0] hist0_q, hist0_d, hist1_q, hist1_d, hist2_q, hist2_d;
    logic [SPEED_W+1:0] speed_sum;

    always_comb begin
        hist0_d   = hist0_q;
        hist1_d   = hist1_q;
        hist2_d   = hist2_q;
        speed_sum = {2'b00, raw_speed} + {2'b00, hist0_q} + {2'b00, hist1_q} + {2'b00, hist2_q};
        speed_new = SPEED_W'(speed_sum >> 2);
        if (window_end) begin
            hist0_d = raw_speed;
            hist1_d = hist0_q;
            hist2_d = hist1_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            hist0_q <= '0;
            hist1_q <= '0;
            hist2_q <= '0;
        end else begin
            hist0_q <= hist0_d;
            hist1_q <= hist1_d;
            hist2_q <= hist2_d;
        end
    end
`else
    assign speed_new = raw_speed;
`endif

    // An edge on the closing cycle is carried into the next window, not the one being reported.
    always_comb begin
        tick_prev_d   = wheel_tick;
        speed_d       = speed_q;
        speed_valid_d = window_end;
        if (window_end) begin
            win_cnt_d  = '0;
            tick_cnt_d = {{(SPEED_W-1){1'b0}}, tick_rise};
            speed_d    = speed_new;
        end else begin
            win_cnt_d  = win_cnt_q + 1'b1;
            tick_cnt_d = (tick_rise && tick_cnt_q != SPEED_MAX) ? tick_cnt_q + 1'b1 : tick_cnt_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            tick_prev_q   <= 1'b0;
            win_cnt_q     <= '0;
            tick_cnt_q    <= '0;
            speed_q       <= '0;
            speed_valid_q <= 1'b0;
        end else begin
            tick_prev_q   <= tick_prev_d;
            win_cnt_q     <= win_cnt_d;
            tick_cnt_q    <= tick_cnt_d;
            speed_q       <= speed_d;
            speed_valid_q <= speed_valid_d;
        end
    end

    echo_ranger #(
        .TRIG_CYCLES     (TRIG_CYCLES),
        .CYCLES_PER_METER(CYCLES_PER_METER),
        .ECHO_TIMEOUT    (ECHO_TIMEOUT),
        .PING_PERIOD     (PING_PERIOD)
    ) u_ranger (
        .CLK             (CLK),
        .rst             (rst),
        .echo            (echo),
        .trig            (trig),
        .leading_distance(leading_distance),
        .dist_valid      (dist_valid)
    );

endmodule
